// File: rtl/ooop_rs_pkg.sv
// ooop_rs_pkg -- shared types for the out-of-order pipeline reservation stations.
//
// Provides the physical register tag width, the functional-unit type enum,
// the reservation-station entry record and two small helpers used by the RS:
//   srcs_ready() : entry has every used source operand ready
//   cdb_wake()   : entry with ready bits updated by one CDB broadcast
//
// Related build option: OOOP_RS_AGE_SELECT_EN (see ooop_rs.sv).
package ooop_rs_pkg;

    localparam int unsigned PREG_W = 7;
    localparam int unsigned ROB_W  = 6;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_BRU = 2'd1,
        FU_LSU = 2'd2
    } fu_type_e;

    typedef struct packed {
        fu_type_e            fu_type;
        logic [3:0]          uop;
        logic [PREG_W-1:0]   prd;
        logic [PREG_W-1:0]   prs1;
        logic                rs1_used;
        logic                prs1_ready;
        logic [PREG_W-1:0]   prs2;
        logic                rs2_used;
        logic                prs2_ready;
        logic [ROB_W-1:0]    rob_idx;
        logic [31:0]         imm;
    } rs_entry_t;

    // An unused source counts as ready whatever its ready bit says.
    function automatic logic srcs_ready(input rs_entry_t e);
        return (!e.rs1_used || e.prs1_ready) && (!e.rs2_used || e.prs2_ready);
    endfunction

    function automatic rs_entry_t cdb_wake(input rs_entry_t        e,
                                           input logic             cdb_valid,
                                           input logic [PREG_W-1:0] cdb_ptag);
        rs_entry_t r;
        r = e;
        if (cdb_valid && e.rs1_used && (e.prs1 == cdb_ptag)) r.prs1_ready = 1'b1;
        if (cdb_valid && e.rs2_used && (e.prs2 == cdb_ptag)) r.prs2_ready = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/ooop_rs_select.sv
// ooop_rs_select -- combinational one-hot picker for the reservation station.
//
// Build option OOOP_RS_AGE_SELECT_EN:
//   defined   : grants the oldest requester according to the age matrix
//   undefined : grants the lowest-index requester (no age port)
//
// Ports:
//   age   in  DEPTH x DEPTH  age[i][j]=1 means slot i is younger than slot j
//                            (only present with OOOP_RS_AGE_SELECT_EN)
//   req   in  DEPTH          request vector
//   grant out DEPTH          one-hot grant, '0 when nothing requests
//   found out 1              at least one request was granted
module ooop_rs_select #(
    parameter int unsigned DEPTH = 8
) (
`ifdef OOOP_RS_AGE_SELECT_EN
    input  logic [DEPTH-1:0][DEPTH-1:0] age,
`endif
    input  logic [DEPTH-1:0]            req,
    output logic [DEPTH-1:0]            grant,
    output logic                        found
);

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef OOOP_RS_AGE_SELECT_EN
            // Oldest requester: younger than no other requester.
            if (req[i] && ((age[i] & req) == '0)) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
`else
            if (req[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
`endif
        end
    end

endmodule

// File: rtl/ooop_rs.sv
// ooop_rs -- generic reservation station in front of one functional unit.
//
// Holds dispatched micro-ops until their physical sources are ready (CDB
// snooping, including wakeup of the entry being inserted), then presents one
// eligible entry per cycle to the FU. Cleared synchronously by flush_i.
//
// Build option OOOP_RS_AGE_SELECT_EN:
//   defined   : oldest-eligible issue using a DEPTH x DEPTH age matrix
//   undefined : lowest-index eligible issue, no age matrix
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush_i           clear all entries at the next edge
//   insert_valid_i    dispatch presents insert_entry_i
//   insert_entry_i    entry to insert
//   ready_o           at least one free slot (registered state only)
//   cdb_valid_i       CDB broadcast valid
//   cdb_ptag_i        CDB produced physical tag
//   issue_valid_o     an eligible entry is presented
//   issue_entry_o     selected entry, '0 when issue_valid_o=0
//   issue_ready_i     FU accepts the presented entry
//   count_o           number of occupied slots (registered)
module ooop_rs
    import ooop_rs_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PREG_W = ooop_rs_pkg::PREG_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       insert_valid_i,
    input  rs_entry_t                  insert_entry_i,
    output logic                       ready_o,
    input  logic                       cdb_valid_i,
    input  logic [PREG_W-1:0]          cdb_ptag_i,
    output logic                       issue_valid_o,
    output rs_entry_t                  issue_entry_o,
    input  logic                       issue_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = $bits(rs_entry_t);

    logic [DEPTH-1:0] valid_q;
    rs_entry_t        slot_q [DEPTH];
    logic [CNT_W-1:0] count_q;

    logic [DEPTH-1:0] eligible;
    logic [DEPTH-1:0] issue_grant;
    logic             issue_found;
    logic [DEPTH-1:0] alloc_grant;
    logic             alloc_found;
    logic             insert_fire;
    logic             issue_fire;
    logic [ENTRY_W-1:0] issue_bits;
    rs_entry_t        insert_woken;

    // Eligibility uses registered ready bits only: no CDB-to-issue bypass.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            eligible[i] = valid_q[i] && srcs_ready(slot_q[i]);
        end
    end

`ifdef OOOP_RS_AGE_SELECT_EN
    logic [DEPTH-1:0][DEPTH-1:0] age_q;

    ooop_rs_select #(.DEPTH(DEPTH)) u_issue_sel (
        .age   (age_q),
        .req   (eligible),
        .grant (issue_grant),
        .found (issue_found)
    );

    always_comb begin
        alloc_grant = '0;
        alloc_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !alloc_found) begin
                alloc_grant[i] = 1'b1;
                alloc_found    = 1'b1;
            end
        end
    end

    // A newly inserted slot becomes younger than every currently valid slot;
    // clearing its column keeps stale bits from older occupants out of later rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= '0;
        end else if (flush_i) begin
            age_q <= '0;
        end else if (insert_fire) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    if (alloc_grant[i]) begin
                        age_q[i][j] <= valid_q[j];
                    end else if (alloc_grant[j]) begin
                        age_q[i][j] <= 1'b0;
                    end
                end
            end
        end
    end
`else
    ooop_rs_select #(.DEPTH(DEPTH)) u_issue_sel (
        .req   (eligible),
        .grant (issue_grant),
        .found (issue_found)
    );

    ooop_rs_select #(.DEPTH(DEPTH)) u_alloc_sel (
        .req   (~valid_q),
        .grant (alloc_grant),
        .found (alloc_found)
    );
`endif

    assign ready_o       = alloc_found;
    assign issue_valid_o = issue_found;
    assign count_o       = count_q;
    assign insert_fire   = insert_valid_i && ready_o;
    assign issue_fire    = issue_valid_o && issue_ready_i;
    assign insert_woken  = cdb_wake(insert_entry_i, cdb_valid_i, cdb_ptag_i);

    always_comb begin
        issue_bits = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (issue_grant[i]) issue_bits = issue_bits | slot_q[i];
        end
    end

    assign issue_entry_o = rs_entry_t'(issue_bits);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else if (flush_i) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= (valid_q & ~(issue_fire ? issue_grant : '0))
                     | (insert_fire ? alloc_grant : '0);
            count_q <= count_q + CNT_W'(insert_fire) - CNT_W'(issue_fire);
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (insert_fire && alloc_grant[i]) begin
                    slot_q[i] <= insert_woken;
                end else if (valid_q[i]) begin
                    slot_q[i] <= cdb_wake(slot_q[i], cdb_valid_i, cdb_ptag_i);
                end
            end
        end
    end

    a_no_insert_when_full : assert property (
        @(posedge clk) disable iff (!rst_n) !(insert_valid_i && !ready_o)
    );

endmodule

// File: tb/tb_ooop_rs.sv
module tb_ooop_rs;
    import ooop_rs_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush_i;
    logic            insert_valid_i;
    rs_entry_t       insert_entry_i;
    logic            ready_o;
    logic            cdb_valid_i;
    logic [PREG_W-1:0] cdb_ptag_i;
    logic            issue_valid_o;
    rs_entry_t       issue_entry_o;
    logic            issue_ready_i;
    logic [3:0]      count_o;

    int vectors     = 0;
    int miscompares = 0;
    rs_entry_t exp_q[$];
    rs_entry_t mon_exp;

    always #5 clk = ~clk;

    ooop_rs #(.DEPTH(DEPTH), .PREG_W(PREG_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .insert_valid_i (insert_valid_i),
        .insert_entry_i (insert_entry_i),
        .ready_o        (ready_o),
        .cdb_valid_i    (cdb_valid_i),
        .cdb_ptag_i     (cdb_ptag_i),
        .issue_valid_o  (issue_valid_o),
        .issue_entry_o  (issue_entry_o),
        .issue_ready_i  (issue_ready_i),
        .count_o        (count_o)
    );

    function automatic rs_entry_t mk(input int rob, input int p1, input logic u1, input logic r1,
                                     input int p2, input logic u2, input logic r2);
        rs_entry_t e;
        e = '0;
        e.fu_type    = FU_ALU;
        e.uop        = 4'(rob);
        e.prd        = PREG_W'(rob);
        e.prs1       = PREG_W'(p1);
        e.rs1_used   = u1;
        e.prs1_ready = r1;
        e.prs2       = PREG_W'(p2);
        e.rs2_used   = u2;
        e.prs2_ready = r2;
        e.rob_idx    = ROB_W'(rob);
        e.imm        = 32'(rob * 7 + 1);
        return e;
    endfunction

    // At issue time every used source must have been marked ready.
    function automatic rs_entry_t at_issue(input rs_entry_t e);
        rs_entry_t r;
        r = e;
        if (r.rs1_used) r.prs1_ready = 1'b1;
        if (r.rs2_used) r.prs2_ready = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        insert_valid_i = 1'b0;
        insert_entry_i = '0;
        cdb_valid_i    = 1'b0;
        cdb_ptag_i     = '0;
        flush_i        = 1'b0;
    endtask

    // Scoreboard: every accepted issue pops the next expected entry.
    always @(negedge clk) begin
        if (rst_n && issue_valid_o && issue_ready_i) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL issue_unexpected: got rob %0d, required no issue", issue_entry_o.rob_idx);
            end else begin
                mon_exp = exp_q.pop_front();
                if (issue_entry_o !== mon_exp) begin
                    miscompares++;
                    $display("FAIL issue_entry: got rob %0d (%h), required rob %0d (%h)",
                             issue_entry_o.rob_idx, issue_entry_o, mon_exp.rob_idx, mon_exp);
                end
            end
        end
    end

    task automatic drain(input string name);
        int unsigned n;
        issue_ready_i = 1'b1;
        n = 0;
        do begin
            tick();
            @(negedge clk);
            n++;
        end while (!(count_o == 0 && !issue_valid_o) && n < 40);
        vectors++;
        if (count_o !== 4'd0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: count %0d pending %0d, required 0 and 0", name, count_o, exp_q.size());
        end
        tick();
        issue_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        issue_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors += 4;
        if (issue_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_issue_valid: got %b, required 0", issue_valid_o); end
        if (issue_entry_o !== rs_entry_t'('0)) begin miscompares++; $display("FAIL reset_issue_entry: got %h, required 0", issue_entry_o); end
        if (ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b, required 1", ready_o); end
        if (count_o !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d, required 0", count_o); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        rs_entry_t e;
        e = mk(1, 3, 1'b1, 1'b1, 4, 1'b1, 1'b1);
        tick();
        insert_valid_i = 1'b1;
        insert_entry_i = e;
        exp_q.push_back(at_issue(e));
        tick();
        idle_inputs();
        issue_ready_i = 1'b1;
        @(negedge clk);
        vectors += 2;
        if (issue_valid_o !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b, required 1", issue_valid_o); end
        if (count_o !== 4'd1) begin miscompares++; $display("FAIL single_count: got %0d, required 1", count_o); end
        tick();
        issue_ready_i = 1'b0;
        @(negedge clk);
        vectors += 3;
        if (count_o !== 4'd0) begin miscompares++; $display("FAIL single_count_after: got %0d, required 0", count_o); end
        if (issue_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_valid_after: got %b, required 0", issue_valid_o); end
        if (issue_entry_o !== rs_entry_t'('0)) begin miscompares++; $display("FAIL single_idle_entry: got %h, required 0", issue_entry_o); end
    endtask

    task automatic test_fill_wakeup();
        rs_entry_t e;
        issue_ready_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            e = mk(10 + k, 5, 1'b1, 1'b0, 0, 1'b0, 1'b0);
            insert_valid_i = 1'b1;
            insert_entry_i = e;
            exp_q.push_back(at_issue(e));
        end
        tick();
        idle_inputs();
        @(negedge clk);
        vectors += 3;
        if (ready_o !== 1'b0) begin miscompares++; $display("FAIL fill_ready: got %b, required 0", ready_o); end
        if (issue_valid_o !== 1'b0) begin miscompares++; $display("FAIL fill_valid: got %b, required 0", issue_valid_o); end
        if (count_o !== 4'd8) begin miscompares++; $display("FAIL fill_count: got %0d, required 8", count_o); end
        tick();
        cdb_valid_i   = 1'b1;
        cdb_ptag_i    = PREG_W'(5);
        issue_ready_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (issue_valid_o !== 1'b0) begin miscompares++; $display("FAIL fill_no_bypass: got %b, required 0", issue_valid_o); end
        tick();
        idle_inputs();
        @(negedge clk);
        vectors++;
        if (issue_valid_o !== 1'b1) begin miscompares++; $display("FAIL fill_wake_valid: got %b, required 1", issue_valid_o); end
        drain("fill");
    endtask

    task automatic test_insert_wakeup();
        rs_entry_t e;
        issue_ready_i = 1'b0;
        e = mk(20, 0, 1'b0, 1'b0, 9, 1'b1, 1'b0);
        tick();
        insert_valid_i = 1'b1;
        insert_entry_i = e;
        cdb_valid_i    = 1'b1;
        cdb_ptag_i     = PREG_W'(9);
        exp_q.push_back(at_issue(e));
        tick();
        idle_inputs();
        @(negedge clk);
        vectors++;
        if (issue_valid_o !== 1'b1) begin miscompares++; $display("FAIL insert_wake_valid: got %b, required 1", issue_valid_o); end
        drain("insert_wake");
    endtask

    task automatic test_stall();
        rs_entry_t e;
        issue_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            e = mk(30 + k, 1, 1'b1, 1'b1, 2, 1'b1, 1'b1);
            insert_valid_i = 1'b1;
            insert_entry_i = e;
            exp_q.push_back(at_issue(e));
        end
        tick();
        idle_inputs();
        for (int c = 0; c < 5; c++) begin
            tick();
            @(negedge clk);
            vectors += 2;
            if (issue_entry_o.rob_idx !== ROB_W'(30)) begin miscompares++; $display("FAIL stall_entry: got rob %0d, required 30", issue_entry_o.rob_idx); end
            if (count_o !== 4'd2) begin miscompares++; $display("FAIL stall_count: got %0d, required 2", count_o); end
        end
        drain("stall");
    endtask

    task automatic test_age_order();
        rs_entry_t f0, f1, f2, a, b;
        f0 = mk(40, 1, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        f1 = mk(41, 20, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        f2 = mk(42, 20, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        a  = mk(43, 21, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        b  = mk(44, 0, 1'b0, 1'b0, 21, 1'b1, 1'b0);
        issue_ready_i = 1'b0;
        tick(); insert_valid_i = 1'b1; insert_entry_i = f0; exp_q.push_back(at_issue(f0));
        tick(); insert_entry_i = f1;
        tick(); insert_entry_i = f2;
        tick(); insert_entry_i = a;
        tick(); idle_inputs(); issue_ready_i = 1'b1;
        tick(); issue_ready_i = 1'b0; insert_valid_i = 1'b1; insert_entry_i = b;
        tick(); idle_inputs();
        cdb_valid_i = 1'b1;
        cdb_ptag_i  = PREG_W'(21);
        issue_ready_i = 1'b1;
`ifdef OOOP_RS_AGE_SELECT_EN
        exp_q.push_back(at_issue(a));
        exp_q.push_back(at_issue(b));
`else
        exp_q.push_back(at_issue(b));
        exp_q.push_back(at_issue(a));
`endif
        @(negedge clk);
        vectors += 2;
        if (count_o !== 4'd4) begin miscompares++; $display("FAIL age_count: got %0d, required 4", count_o); end
        if (issue_valid_o !== 1'b0) begin miscompares++; $display("FAIL age_no_bypass: got %b, required 0", issue_valid_o); end
        tick(); idle_inputs();
        tick();
        tick();
        cdb_valid_i = 1'b1;
        cdb_ptag_i  = PREG_W'(20);
        exp_q.push_back(at_issue(f1));
        exp_q.push_back(at_issue(f2));
        @(negedge clk);
        vectors++;
        if (count_o !== 4'd2) begin miscompares++; $display("FAIL age_count_left: got %0d, required 2", count_o); end
        tick(); idle_inputs();
        drain("age");
    endtask

    task automatic test_flush();
        issue_ready_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            insert_valid_i = 1'b1;
            insert_entry_i = mk(60 + k, 50, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        end
        tick();
        flush_i        = 1'b1;
        insert_valid_i = 1'b1;
        insert_entry_i = mk(66, 1, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        tick();
        idle_inputs();
        @(negedge clk);
        vectors += 3;
        if (count_o !== 4'd0) begin miscompares++; $display("FAIL flush_count: got %0d, required 0", count_o); end
        if (ready_o !== 1'b1) begin miscompares++; $display("FAIL flush_ready: got %b, required 1", ready_o); end
        if (issue_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b, required 0", issue_valid_o); end
        tick();
        issue_ready_i = 1'b1;
        cdb_valid_i   = 1'b1;
        cdb_ptag_i    = PREG_W'(50);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (issue_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_stale_issue: got %b, required 0", issue_valid_o); end
            tick();
            idle_inputs();
        end
        issue_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        rs_entry_t e;
        issue_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            e = mk(70 + k, 3, 1'b1, 1'b1, 4, 1'b1, 1'b1);
            insert_valid_i = 1'b1;
            insert_entry_i = e;
            exp_q.push_back(at_issue(e));
            @(negedge clk);
            if (k > 0) begin
                vectors += 2;
                if (count_o !== 4'd1) begin miscompares++; $display("FAIL b2b_count: got %0d, required 1", count_o); end
                if (issue_valid_o !== 1'b1) begin miscompares++; $display("FAIL b2b_valid: got %b, required 1", issue_valid_o); end
            end
        end
        tick();
        idle_inputs();
        drain("b2b");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_fill_wakeup();
        test_insert_wakeup();
        test_stall();
        test_age_order();
        test_flush();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
